// File: rtl/game_fsm.sv
// game_fsm: top-level play-session sequencer for the flappy bird design.
// Walks IDLE -> PLAY -> DYING -> GAMEOVER -> PLAY, gates the physics/pipe
// datapath with play_en, pulses game_reset on every entry to PLAY, selects
// the game-over overlay and keeps the score.
//
// Optional feature macro: GAME_FSM_BEST_SCORE_EN
//   defined     -> a best-score register is kept and updated on DYING->GAMEOVER
//   not defined -> no best register; best is tied to zero
module game_fsm #(
    parameter int DIE_FRAMES  = 30,   // frames in DYING before GAMEOVER (1..255)
    parameter int LOCK_FRAMES = 60,   // restart lockout frames in GAMEOVER (1..255)
    parameter int SCORE_MAX   = 999   // score saturation value (< 1024)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn,
    input  logic       collide,
    input  logic       pipe_passed,
    output logic [1:0] state,
    output logic       play_en,
    output logic       game_reset,
    output logic       gameover_en,
    output logic [9:0] score,
    output logic [9:0] best
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAY     = 2'd1,
        ST_DYING    = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    localparam logic [7:0] DIE_LAST  = 8'(DIE_FRAMES);
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_FRAMES);
    localparam logic [9:0] SCORE_TOP = 10'(SCORE_MAX);

    state_t     state_q;
    logic [7:0] frame_cnt;
    logic [9:0] score_q;
    logic       btn_q;
    logic       press;

`ifdef GAME_FSM_BEST_SCORE_EN
    logic [9:0] best_q;
`endif

    // Rising edge of the (already clean) button level. btn_q resets high so
    // a button held through reset never looks like a fresh press.
    assign press = btn & ~btn_q;

    // Button history register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b1;
        end else begin
            btn_q <= btn;
        end
    end

    // Session state machine; every output is produced directly by a flop here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            play_en     <= 1'b0;
            game_reset  <= 1'b0;
            gameover_en <= 1'b0;
            score_q     <= '0;
            frame_cnt   <= '0;
`ifdef GAME_FSM_BEST_SCORE_EN
            best_q      <= '0;
`endif
        end else begin
            // game_reset is a single-cycle strobe; only restart branches raise it.
            game_reset <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    score_q <= '0;
                    if (press) begin
                        state_q     <= ST_PLAY;
                        play_en     <= 1'b1;
                        game_reset  <= 1'b1;
                        gameover_en <= 1'b0;
                        frame_cnt   <= '0;
                    end
                end

                ST_PLAY: begin
                    // Score and collision are evaluated independently so a
                    // pipe cleared on the fatal cycle still counts.
                    if (pipe_passed) begin
                        if (score_q < SCORE_TOP) begin
                            score_q <= score_q + 10'd1;
                        end else begin
                            score_q <= SCORE_TOP;
                        end
                    end
                    if (collide) begin
                        state_q   <= ST_DYING;
                        play_en   <= 1'b0;
                        frame_cnt <= '0;
                    end
                end

                ST_DYING: begin
                    // Presses and pipe_passed are deliberately ignored here.
                    if (frame_tick) begin
                        if (frame_cnt + 8'd1 == DIE_LAST) begin
                            state_q     <= ST_GAMEOVER;
                            gameover_en <= 1'b1;
                            frame_cnt   <= '0;
`ifdef GAME_FSM_BEST_SCORE_EN
                            if (score_q > best_q) begin
                                best_q <= score_q;
                            end
`endif
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end

                ST_GAMEOVER: begin
                    // Press is judged on the pre-edge count, so a press that
                    // coincides with the unlocking frame_tick is still ignored.
                    if (press && (frame_cnt == LOCK_LAST)) begin
                        state_q     <= ST_PLAY;
                        play_en     <= 1'b1;
                        game_reset  <= 1'b1;
                        gameover_en <= 1'b0;
                        score_q     <= '0;
                        frame_cnt   <= '0;
                    end else if (frame_tick && (frame_cnt < LOCK_LAST)) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    play_en <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;
    assign score = score_q;

`ifdef GAME_FSM_BEST_SCORE_EN
    assign best = best_q;
`else
    assign best = '0;
`endif

endmodule

// File: tb/tb_game_fsm.sv
// Scoreboard bench for game_fsm with default parameters.
// Expected output values are queued as stimulus is applied and compared
// against the DUT after the following clock edge.
`timescale 1ns/1ps
module tb_game_fsm;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       btn;
    logic       collide;
    logic       pipe_passed;
    logic [1:0] state;
    logic       play_en;
    logic       game_reset;
    logic       gameover_en;
    logic [9:0] score;
    logic [9:0] best;

`ifdef GAME_FSM_BEST_SCORE_EN
    localparam bit BEST_ON = 1'b1;
`else
    localparam bit BEST_ON = 1'b0;
`endif

    localparam int S_STATE = 0, S_PLAY = 1, S_GRST = 2, S_GOVR = 3, S_SCORE = 4, S_BEST = 5;

    typedef struct {
        string tag;
        int    sig;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   gr_cnt;
    int   nonidle_cnt;

    game_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn        (btn),
        .collide    (collide),
        .pipe_passed(pipe_passed),
        .state      (state),
        .play_en    (play_en),
        .game_reset (game_reset),
        .gameover_en(gameover_en),
        .score      (score),
        .best       (best)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int observe(input int sig);
        case (sig)
            S_STATE: return int'(state);
            S_PLAY:  return int'(play_en);
            S_GRST:  return int'(game_reset);
            S_GOVR:  return int'(gameover_en);
            S_SCORE: return int'(score);
            default: return int'(best);
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input int val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    // Pop every pending expectation and compare with the current outputs.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sig), e.val);
        end
    endtask

    // One clock: inputs already set, sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (game_reset) gr_cnt++;
        if (state != 2'd0) nonidle_cnt++;
    endtask

    // One frame: a single-cycle frame_tick followed by two quiet cycles.
    task automatic frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        step();
    endtask

    task automatic pass_pipe(input int n);
        for (int i = 0; i < n; i++) begin
            pipe_passed = 1'b1;
            step();
            pipe_passed = 1'b0;
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; btn = 1'b1; frame_tick = 1'b0; collide = 1'b0; pipe_passed = 1'b0;
        gr_cnt = 0; nonidle_cnt = 0;

        // Reset values while held in reset with the button down.
        #22;
        push("rst_state", S_STATE, 0); push("rst_play", S_PLAY, 0);
        push("rst_grst", S_GRST, 0);   push("rst_govr", S_GOVR, 0);
        push("rst_score", S_SCORE, 0); push("rst_best", S_BEST, 0);
        drain();
        rst_n = 1'b1;

        // Button held through reset must not start the game.
        for (int i = 0; i < 100; i++) step();
        check("held_btn_nonidle", nonidle_cnt, 0);
        check("held_btn_grst", gr_cnt, 0);

        // IDLE press -> PLAY with a single game_reset pulse.
        btn = 1'b0; step();
        btn = 1'b1;
        push("start_state", S_STATE, 1); push("start_play", S_PLAY, 1);
        push("start_grst", S_GRST, 1);   push("start_score", S_SCORE, 0);
        step(); drain();
        push("start_grst_drop", S_GRST, 0); push("start_state2", S_STATE, 1);
        step(); drain();
        check("start_grst_count", gr_cnt, 1);
        btn = 1'b0;

        // Five pipes, then collide together with a sixth.
        pass_pipe(5);
        push("five_pipes", S_SCORE, 5); drain();
        collide = 1'b1; pipe_passed = 1'b1;
        push("coll_score", S_SCORE, 6); push("coll_state", S_STATE, 2);
        push("coll_play", S_PLAY, 0);
        step(); drain();
        collide = 1'b0; pipe_passed = 1'b0;

        // DYING ignores pipe_passed and presses; 29 frames stay in DYING.
        pass_pipe(1);
        push("dying_pipe_ignored", S_SCORE, 6); drain();
        for (int i = 0; i < 29; i++) begin
            btn = 1'b1; step(); btn = 1'b0;
            frame();
        end
        push("dying_29", S_STATE, 2); push("dying_govr", S_GOVR, 0); drain();
        frame_tick = 1'b1;
        push("die_to_go", S_STATE, 3); push("die_govr", S_GOVR, 1);
        push("die_best", S_BEST, BEST_ON ? 6 : 0);
        step(); drain();
        frame_tick = 1'b0; step();

        // GAMEOVER lockout: 59 frames, a press is ignored.
        for (int i = 0; i < 59; i++) frame();
        btn = 1'b1;
        push("lock_press_59", S_STATE, 3);
        step(); drain();
        btn = 1'b0; step();
        // Press coinciding with the 60th tick uses the pre-edge count.
        btn = 1'b1; frame_tick = 1'b1;
        push("lock_press_tick60", S_STATE, 3); push("lock_govr", S_GOVR, 1);
        step(); drain();
        btn = 1'b0; frame_tick = 1'b0; step();
        gr_cnt = 0;
        btn = 1'b1;
        push("restart_state", S_STATE, 1); push("restart_score", S_SCORE, 0);
        push("restart_grst", S_GRST, 1);   push("restart_govr", S_GOVR, 0);
        push("restart_play", S_PLAY, 1);
        step(); drain();
        step();
        check("restart_grst_count", gr_cnt, 1);
        btn = 1'b0;

        // Score saturation at 999.
        pass_pipe(999);
        push("score_999", S_SCORE, 999); drain();
        pass_pipe(3);
        push("score_sat", S_SCORE, 999); drain();

        // Second death: best takes the larger score and survives restart.
        collide = 1'b1; step(); collide = 1'b0;
        for (int i = 0; i < 30; i++) frame();
        push("die2_state", S_STATE, 3); push("die2_best", S_BEST, BEST_ON ? 999 : 0);
        drain();
        for (int i = 0; i < 60; i++) frame();
        btn = 1'b1; step(); btn = 1'b0;
        push("restart2_state", S_STATE, 1); push("restart2_score", S_SCORE, 0);
        push("restart2_best", S_BEST, BEST_ON ? 999 : 0);
        drain();
        pass_pipe(2);
        push("play2_score", S_SCORE, 2); drain();

        // Asynchronous reset mid-PLAY, checked before any further clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        push("arst_state", S_STATE, 0); push("arst_play", S_PLAY, 0);
        push("arst_grst", S_GRST, 0);   push("arst_govr", S_GOVR, 0);
        push("arst_score", S_SCORE, 0); push("arst_best", S_BEST, 0);
        drain();
        #20;
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/game_fsm.md
# game_fsm

Top-level game sequencer for the flappy bird design. Tracks the play session through idle, play, dying and game-over phases. Gates the physics/pipe datapath with a play enable and issues a one-cycle restart pulse. Selects the game-over overlay and maintains the score and best score shown by the draw stages. Sits between the input synchronizer/collision detector and the draw/physics blocks, clocked in the pixel clock domain.

## Interface
Parameters:
- DIE_FRAMES, 30, frames spent in DYING before GAMEOVER; legal range 1..255
- LOCK_FRAMES, 60, frames after entering GAMEOVER during which restart presses are ignored; legal range 1..255
- SCORE_MAX, 999, saturation value of score; must be < 1024

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame, start of vblank
- btn  in  1  flap button, already synchronized and debounced (level)
- collide  in  1  collision flag from the collision detector (level or pulse)
- pipe_passed  in  1  one-cycle pulse when the bird clears a pipe
- state  out  2  0=IDLE, 1=PLAY, 2=DYING, 3=GAMEOVER
- play_en  out  1  high only in PLAY; enables physics and pipe scrolling
- game_reset  out  1  one-cycle pulse on every entry to PLAY; clears bird/pipe positions
- gameover_en  out  1  high only in GAMEOVER; selects the game-over overlay
- score  out  10  current score, binary
- best  out  10  best score since reset

## Operation
- Press detect: btn_q is btn registered; press = btn & ~btn_q. btn_q resets to 1, so a button held through reset produces no press.
- IDLE:
  - press -> PLAY
  - score <= 0; game_reset pulses
- PLAY:
  - pipe_passed -> score <= min(score+1, SCORE_MAX)
  - collide -> DYING; frame counter <= 0
  - press has no state effect; flapping is handled by physics
- DYING:
  - play_en=0; presses and pipe_passed ignored
  - frame counter increments on frame_tick
  - on the frame_tick that brings the count to DIE_FRAMES -> GAMEOVER; counter <= 0
  - best updates on this same transition
- GAMEOVER:
  - gameover_en=1; counter increments on frame_tick, saturating at LOCK_FRAMES
  - press while counter == LOCK_FRAMES -> PLAY; score <= 0; game_reset pulses
  - earlier presses are discarded, not queued
- collide and pipe_passed are ignored outside PLAY.
- Frame counter is 8 bits.
- Score arithmetic is unsigned 10-bit and saturates; it never wraps.

## Timing
- All outputs are registered.
- An input sampled at rising edge k is reflected in the outputs after edge k (1-cycle latency).
- game_reset is high for exactly the one cycle following the transition edge; play_en rises in that same cycle.
- Simultaneous collide and pipe_passed in PLAY: the score increments and the state moves to DYING in the same edge.
- Simultaneous press and frame_tick in GAMEOVER: the press is evaluated against the pre-edge counter value.
- Reset values: state=IDLE, play_en=0, game_reset=0, gameover_en=0, score=0, best=0, counter=0, btn_q=1.
- rst_n assertion mid-game clears all state immediately (asynchronous); release is synchronized by the system reset bridge.

## Configuration
- GAME_FSM_BEST_SCORE_EN defined: best register present.
  - On DYING->GAMEOVER, best <= (score > best) ? score : best.
  - best survives restarts and clears only on rst_n.
- Not defined: no best register is synthesized; best is tied to 0.

## Test plan
- Reset with btn held high, then keep btn high 100 cycles -> state stays IDLE, no game_reset pulse.
- IDLE, btn 0->1 -> next cycle state=1, play_en=1, game_reset high for exactly 1 cycle, score=0.
- PLAY, 5 pipe_passed pulses, then collide and pipe_passed together -> score=6, state=2 one cycle later.
- DYING with DIE_FRAMES=30:
  - presses during DYING are ignored
  - state=3 after the 30th frame_tick; best=6 with the macro, 0 without
  - press at frame 59 of GAMEOVER ignored; press after the 60th frame_tick -> state=1, score=0, game_reset pulse.
- Score at SCORE_MAX=999 plus 3 pipe_passed -> score stays 999.
- Deassert rst_n in the middle of PLAY -> all outputs return to reset values without waiting for a clk edge.
